// File: rtl/trap_controller.sv
// Machine-mode trap/CSR unit: selects one trap or mret per event, updates the
// trap CSRs and steers fetch through a valid/ready redirect handshake.
module trap_controller #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exception_valid_i,
  input  logic [3:0]  exception_cause_i,
  input  logic [31:0] exception_tval_i,
  input  logic [31:0] commit_pc_i,
  input  logic        commit_valid_i,
  input  logic        mret_i,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  input  logic [11:0] csr_addr_i,
  input  logic        csr_we_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic        flush_o,
  output logic        stall_o,
  output logic        trap_taken_o
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 4;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [XLEN-1:0] MIE_MASK   = 32'h0000_0888;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t              state_q, state_d;
  logic                mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0]     mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

  logic [XLEN-1:0]     mip_c, irq_pend_c, base_c, target_c;
  logic [CAUSE_W-1:0]  irq_code_c;
  logic                irq_any_c;
  logic                take_exc_c, take_irq_c, take_mret_c;

  // Live interrupt lines and the enabled, pending subset with fixed priority.
  always_comb begin
    mip_c       = '0;
    mip_c[3]    = irq_software_i;
    mip_c[7]    = irq_timer_i;
    mip_c[11]   = irq_external_i;
    irq_pend_c  = mie_q & mip_c & {XLEN{mstatus_mie_q & commit_valid_i}};
    irq_any_c   = |irq_pend_c;
    irq_code_c  = '0;
    if (irq_pend_c[11])     irq_code_c = 4'd11;
    else if (irq_pend_c[3]) irq_code_c = 4'd3;
    else if (irq_pend_c[7]) irq_code_c = 4'd7;
  end

  assign base_c = {mtvec_q[31:2], 2'b00};

  // Next-state and event selection; exception beats interrupt beats mret.
  always_comb begin
    state_d     = state_q;
    take_exc_c  = 1'b0;
    take_irq_c  = 1'b0;
    take_mret_c = 1'b0;
    target_c    = redirect_pc_o;
    case (state_q)
      IDLE: begin
        if (exception_valid_i) begin
          take_exc_c = 1'b1;
          target_c   = base_c;
          state_d    = REDIRECT;
        end else if (irq_any_c) begin
          take_irq_c = 1'b1;
          target_c   = (mtvec_q[1:0] == 2'd1)
                       ? base_c + {26'b0, irq_code_c, 2'b00} : base_c;
          state_d    = REDIRECT;
        end else if (mret_i) begin
          take_mret_c = 1'b1;
          target_c    = mepc_q;
          state_d     = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registered outputs and CSR file; event updates are applied after
  // software writes so they take precedence on a same-cycle collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      flush_o          <= 1'b0;
      stall_o          <= 1'b0;
      trap_taken_o     <= 1'b0;
      mstatus_mie_q    <= 1'b0;
      mstatus_mpie_q   <= 1'b0;
      mie_q            <= '0;
      mtvec_q          <= RESET_MTVEC;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_o <= (state_d == REDIRECT);
      flush_o          <= (state_d == REDIRECT);
      stall_o          <= (state_d == REDIRECT);
      trap_taken_o     <= take_exc_c | take_irq_c;
      if (take_exc_c | take_irq_c | take_mret_c) redirect_pc_o <= target_c;

      if (csr_we_i) begin
        case (csr_addr_i)
          ADDR_MSTATUS: begin
            mstatus_mie_q  <= csr_wdata_i[3];
            mstatus_mpie_q <= csr_wdata_i[7];
          end
          ADDR_MIE:      mie_q      <= csr_wdata_i & MIE_MASK;
          ADDR_MTVEC:    mtvec_q    <= {csr_wdata_i[31:2],
                                        (csr_wdata_i[1] ? 2'b00 : csr_wdata_i[1:0])};
          ADDR_MSCRATCH: mscratch_q <= csr_wdata_i;
          ADDR_MEPC:     mepc_q     <= csr_wdata_i & ALIGN_MASK;
          ADDR_MCAUSE:   mcause_q   <= csr_wdata_i;
          ADDR_MTVAL:    mtval_q    <= csr_wdata_i;
          default: ;
        endcase
      end

      if (take_exc_c | take_irq_c) begin
        mepc_q         <= commit_pc_i & ALIGN_MASK;
        mcause_q       <= take_exc_c ? {1'b0, 27'b0, exception_cause_i}
                                     : {1'b1, 27'b0, irq_code_c};
        mtval_q        <= take_exc_c ? exception_tval_i : '0;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (take_mret_c) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end
    end
  end

  // Combinational CSR read port.
  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      ADDR_MSTATUS: begin
        csr_rdata_o[12:11] = 2'b11;
        csr_rdata_o[7]     = mstatus_mpie_q;
        csr_rdata_o[3]     = mstatus_mie_q;
      end
      ADDR_MIE:      csr_rdata_o = mie_q;
      ADDR_MTVEC:    csr_rdata_o = mtvec_q;
      ADDR_MSCRATCH: csr_rdata_o = mscratch_q;
      ADDR_MEPC:     csr_rdata_o = mepc_q;
      ADDR_MCAUSE:   csr_rdata_o = mcause_q;
      ADDR_MTVAL:    csr_rdata_o = mtval_q;
      ADDR_MIP:      csr_rdata_o = mip_c;
      default:       csr_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed test-plan steps followed by randomized traffic, all checked against
// a behavioural model of the trap unit kept in this bench.
module tb_trap_controller;

  localparam logic [31:0] RESET_MTVEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exc_v = 1'b0;
  logic [3:0]  cause = '0;
  logic [31:0] tval = '0;
  logic [31:0] pc = '0;
  logic        cv = 1'b0;
  logic        mret = 1'b0;
  logic        sw = 1'b0, tim = 1'b0, ext = 1'b0;
  logic [11:0] caddr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rv;
  logic [31:0] rpc;
  logic        ready = 1'b0;
  logic        flush, stall, taken;

  trap_controller #(.RESET_MTVEC(RESET_MTVEC)) dut (
    .clk_i(clk), .rst_i(rst),
    .exception_valid_i(exc_v), .exception_cause_i(cause), .exception_tval_i(tval),
    .commit_pc_i(pc), .commit_valid_i(cv), .mret_i(mret),
    .irq_software_i(sw), .irq_timer_i(tim), .irq_external_i(ext),
    .csr_addr_i(caddr), .csr_we_i(we), .csr_wdata_i(wdata), .csr_rdata_o(rdata),
    .redirect_valid_o(rv), .redirect_pc_o(rpc), .redirect_ready_i(ready),
    .flush_o(flush), .stall_o(stall), .trap_taken_o(taken)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_mie, m_mpie, busy, exp_taken, was_reset;
  logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval, exp_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    caddr = a;
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    caddr = a; we = 1'b1; wdata = d;
  endtask

  // One clock: advance the model from the current inputs, clock the DUT, compare.
  task automatic tick();
    logic [31:0] mip, pend, base, rd;
    logic [11:0] addrs [9];
    logic [31:0] exps  [9];
    int          code;
    bit          blk_trap, blk_st;
    blk_trap = 0; blk_st = 0; exp_taken = 0; was_reset = 0;
    base = m_tvec & 32'hFFFF_FFFC;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = RESET_MTVEC; m_scratch = 0;
      m_epc = 0; m_cause = 0; m_tval = 0; busy = 0; exp_pc = 0; was_reset = 1;
    end else begin
      if (!busy) begin
        mip  = (32'(ext) << 11) | (32'(sw) << 3) | (32'(tim) << 7);
        pend = (m_mie && cv) ? (m_ie & mip) : 32'd0;
        if (exc_v) begin
          exp_pc = base;
          m_epc = pc & 32'hFFFF_FFFC; m_cause = 32'(cause); m_tval = tval;
          m_mpie = m_mie; m_mie = 0;
          busy = 1; exp_taken = 1; blk_trap = 1; blk_st = 1;
        end else if (pend != 0) begin
          code = pend[11] ? 11 : (pend[3] ? 3 : 7);
          exp_pc = (m_tvec[1:0] == 2'd1) ? base + 32'(4 * code) : base;
          m_epc = pc & 32'hFFFF_FFFC; m_cause = 32'h8000_0000 | 32'(code); m_tval = 0;
          m_mpie = m_mie; m_mie = 0;
          busy = 1; exp_taken = 1; blk_trap = 1; blk_st = 1;
        end else if (mret) begin
          exp_pc = m_epc;
          m_mie = m_mpie; m_mpie = 1;
          busy = 1; blk_st = 1;
        end
      end else if (ready) begin
        busy = 0;
      end
      if (we) begin
        case (caddr)
          12'h300: if (!blk_st) begin m_mie = wdata[3]; m_mpie = wdata[7]; end
          12'h304: m_ie = wdata & 32'h888;
          12'h305: m_tvec = (wdata[1:0] >= 2) ? (wdata & 32'hFFFF_FFFC) : wdata;
          12'h340: m_scratch = wdata;
          12'h341: if (!blk_trap) m_epc = wdata & 32'hFFFF_FFFC;
          12'h342: if (!blk_trap) m_cause = wdata;
          12'h343: if (!blk_trap) m_tval = wdata;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    rst = 0; exc_v = 0; mret = 0; we = 0;
    check("redirect_valid", 32'(rv), 32'(busy));
    check("flush", 32'(flush), 32'(busy));
    check("stall", 32'(stall), 32'(busy));
    check("trap_taken", 32'(taken), 32'(exp_taken));
    if (busy || was_reset) check("redirect_pc", rpc, exp_pc);
    addrs = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h7C0};
    exps  = '{32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7), m_ie,
              (32'(ext) << 11) | (32'(sw) << 3) | (32'(tim) << 7),
              m_tvec, m_scratch, m_epc, m_cause, m_tval, 32'd0};
    for (int i = 0; i < 9; i++) begin
      csr_read(addrs[i], rd);
      check($sformatf("csr_%h", addrs[i]), rd, exps[i]);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  causes [5];
    logic [11:0] waddr  [9];
    causes = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd11};
    waddr  = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};

    // Reset
    rst = 1; tick();
    rst = 1; tick();
    csr_read(12'h300, d); check("rst_mstatus", d, 32'h1800);
    csr_read(12'h305, d); check("rst_mtvec", d, RESET_MTVEC);

    // Illegal instruction, direct mode, ready high
    pc = 32'h80; cause = 4'd2; tval = 32'hDEAD_BEEF; exc_v = 1; ready = 1; tick();
    check("ill_pc", rpc, 32'h100);
    check("ill_taken", 32'(taken), 32'd1);
    csr_read(12'h341, d); check("ill_mepc", d, 32'h80);
    csr_read(12'h342, d); check("ill_mcause", d, 32'd2);
    csr_read(12'h343, d); check("ill_mtval", d, 32'hDEAD_BEEF);
    csr_read(12'h300, d); check("ill_mie_clear", d & 32'h8, 32'd0);
    tick();
    check("ill_one_cycle", 32'(rv), 32'd0);

    // Vectored timer interrupt
    wr(12'h305, 32'h201); tick();
    wr(12'h300, 32'h8);   tick();
    wr(12'h304, 32'h80);  tick();
    tim = 1; cv = 1; pc = 32'h1000; tick();
    csr_read(12'h342, d); check("tmr_mcause", d, 32'h8000_0007);
    check("tmr_pc", rpc, 32'h21C);
    tim = 0; tick();

    // Exception beats simultaneous external + software; then external
    wr(12'h304, 32'h888); tick();
    wr(12'h300, 32'h8);   tick();
    ext = 1; sw = 1; exc_v = 1; cause = 4'd4; pc = 32'h2000; tick();
    csr_read(12'h342, d); check("sim_exc_mcause", d, 32'd4);
    wr(12'h300, 32'h8); tick();
    tick();
    csr_read(12'h342, d); check("sim_ext_mcause", d, 32'h8000_000B);
    check("sim_ext_pc", rpc, 32'h22C);
    ext = 0; sw = 0; cv = 0; tick();

    // mret with ready held low for three cycles
    wr(12'h341, 32'h84); tick();
    wr(12'h300, 32'h80); tick();
    mret = 1; ready = 0; tick();
    check("mret_pc", rpc, 32'h84);
    csr_read(12'h300, d); check("mret_mstatus", d, 32'h1888);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mret_hold", 32'(rv & stall & flush), 32'd1);
    end
    ready = 1; tick();
    check("mret_release", 32'(rv), 32'd0);

    // CSR write to mepc colliding with ecall
    pc = 32'h40; exc_v = 1; cause = 4'd11; wr(12'h341, 32'h123); tick();
    csr_read(12'h341, d); check("ecall_mepc", d, 32'h40);
    tick();
    wr(12'h341, 32'h123); tick();
    csr_read(12'h341, d); check("mepc_align", d, 32'h120);

    // Reset during REDIRECT
    ready = 0; exc_v = 1; cause = 4'd6; pc = 32'h300; tick();
    check("pre_rst_valid", 32'(rv), 32'd1);
    rst = 1; tick();
    check("rst_abort", 32'(rv | flush | stall | taken), 32'd0);
    check("rst_abort_pc", rpc, 32'd0);
    csr_read(12'h305, d); check("rst_abort_mtvec", d, RESET_MTVEC);
    csr_read(12'h300, d); check("rst_abort_mstatus", d, 32'h1800);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      pc    = $urandom & 32'hFFFF_FFFC;
      exc_v = ($urandom_range(0, 5) == 0);
      cause = causes[$urandom_range(0, 4)];
      tval  = $urandom;
      cv    = 1'($urandom_range(0, 1));
      mret  = ($urandom_range(0, 7) == 0);
      sw    = ($urandom_range(0, 3) == 0);
      tim   = ($urandom_range(0, 3) == 0);
      ext   = ($urandom_range(0, 3) == 0);
      ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) wr(waddr[$urandom_range(0, 8)], $urandom);
      rst   = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Machine-mode trap and CSR unit at the commit end of the core. It consumes the exception cause and pending-interrupt information produced alongside the pipeline stall/flush logic. It selects and takes one trap per event, updates the machine trap CSRs, and steers fetch to the handler address (or back to `mepc` on `mret`) through a valid/ready redirect handshake. While a trap or return is in flight it holds the pipeline stalled and flushed.

## Interface
- `RESET_MTVEC`, default `32'h0000_0100`: reset value of `mtvec`; bits [1:0] give the reset mode.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `exception_valid_i`  in  1  an exception is present at commit this cycle.
- `exception_cause_i`  in  4  cause code: 0 instr-misaligned, 2 illegal, 4 load-misaligned, 6 store-misaligned, 11 ecall-M.
- `exception_tval_i`  in  32  faulting address or instruction, written to `mtval`.
- `commit_pc_i`  in  32  PC of the instruction at commit.
- `commit_valid_i`  in  1  a valid instruction boundary exists; interrupts may only be taken when this is 1.
- `mret_i`  in  1  `mret` is committing.
- `irq_software_i`, `irq_timer_i`, `irq_external_i`  in  1 each  level interrupt lines.
- `csr_addr_i`  in  12  CSR address.
- `csr_we_i`  in  1  CSR write strobe.
- `csr_wdata_i`  in  32  CSR write data.
- `csr_rdata_o`  out  32  combinational read of `csr_addr_i`; unimplemented addresses read 0.
- `redirect_valid_o`  out  1  redirect target is valid.
- `redirect_pc_o`  out  32  redirect target address.
- `redirect_ready_i`  in  1  fetch accepts the redirect.
- `flush_o`  out  1  flush all stages.
- `stall_o`  out  1  stall all stages.
- `trap_taken_o`  out  1  one-cycle pulse when a trap is accepted.

## Operation
- CSRs:
  - `mstatus` (0x300): MIE bit 3, MPIE bit 7, MPP [12:11] hardwired to 2'b11; all other bits read 0.
  - `mie` (0x304): bits 3, 7, 11 writable.
  - `mip` (0x344): read-only; bit 3 = software, bit 7 = timer, bit 11 = external line.
  - `mtvec` (0x305): mode [1:0], where 0 is direct and 1 is vectored; writes of mode ≥ 2 store 0.
  - `mscratch` (0x340), `mepc` (0x341, bits [1:0] forced 0), `mcause` (0x342), `mtval` (0x343).
- FSM states IDLE, REDIRECT.
- In IDLE, event priority is exception > interrupt > `mret`.
- Interrupt pending means `mstatus.MIE & mie[i] & mip[i] & commit_valid_i`. Priority among interrupts: external (11) > software (3) > timer (7).
- Trap acceptance, all updated at the same edge:
  - `mepc` = `commit_pc_i`.
  - `mcause` = {1'b0, 27'b0, cause} for an exception, or {1'b1, 27'b0, code} for an interrupt.
  - `mtval` = `exception_tval_i` for an exception, 0 for an interrupt.
  - MPIE = MIE, then MIE = 0.
- Target address:
  - Direct mode: {`mtvec`[31:2], 2'b00}.
  - Vectored mode with an interrupt: {`mtvec`[31:2], 2'b00} + 4·code (32-bit wrap).
  - Vectored mode with an exception: uses the base address.
- `mret` acceptance: MIE = MPIE, MPIE = 1; target = `mepc`.
- On acceptance the FSM goes to REDIRECT. In REDIRECT, `redirect_valid_o`, `flush_o` and `stall_o` are 1 and the target is held. When `redirect_ready_i` = 1 the FSM returns to IDLE.
- Inputs other than the CSR port are ignored outside IDLE.
- A CSR write in the same cycle as trap/`mret` acceptance: the trap/`mret` update wins for `mstatus`, `mepc`, `mcause` and `mtval`. Writes to other CSRs complete normally.

## Timing
- Reset: all outputs 0, FSM IDLE, `mstatus` = 0x0000_1800, `mtvec` = `RESET_MTVEC`, all other CSRs 0.
- An event sampled in cycle N produces CSR updates visible from cycle N+1. `redirect_valid_o` is 1 from cycle N+1. `trap_taken_o` pulses in cycle N+1.
- `redirect_pc_o` is stable while `redirect_valid_o` = 1.
- If `redirect_ready_i` = 1 in cycle N+1, the FSM is IDLE in N+2; the minimum trap latency is 2 cycles. Ready held low holds REDIRECT indefinitely.
- Reset asserted in REDIRECT aborts the redirect; outputs are 0 the next cycle.
- The earliest new event acceptance is the first IDLE cycle after REDIRECT.

## Test plan
- Illegal instruction: `commit_pc_i` = 0x80, cause 2, tval 0xDEAD_BEEF, `mtvec` = 0x100, ready = 1 -> `mepc` = 0x80, `mcause` = 2, `mtval` = 0xDEAD_BEEF, redirect 0x100 for one cycle, MIE = 0.
- Vectored timer interrupt: `mtvec` = 0x201, MIE = 1, `mie`[7] = 1, timer high -> `mcause` = 0x8000_0007, redirect 0x21C.
- Simultaneous external + software + exception cause 4 -> exception taken, `mcause` = 4. Next IDLE cycle with MIE re-enabled selects external, `mcause` = 0x8000_000B.
- `mret` after a trap: `mepc` = 0x84, MPIE = 1 -> redirect 0x84, MIE = 1, MPIE = 1. Ready held low 3 cycles -> `redirect_valid_o`, `stall_o`, `flush_o` held 4 cycles.
- CSR write to `mepc` (0x341) with data 0x123 in the same cycle as an ecall at PC 0x40 -> `mepc` = 0x40. A separate write of 0x123 -> `mepc` reads 0x120.
- Reset asserted during REDIRECT -> the next cycle has all outputs 0, `mtvec` = `RESET_MTVEC`, `mstatus` = 0x1800.
